ac97_frame_receiver: RTL and testbench

- Receive side of the audio codec link. Deserializes the codec's AUDIO_SDATA_IN stream into 256-bit AC97 input frames.
- Extracts:
  - the codec-ready tag;
  - register status address and data (slots 1–2);
  - PCM left and right capture samples (slots 3–4).
- Becomes active once the reset sequencer raises audio_ready.
- Downstream blocks use codec_ready, which confirms that the codec came out of reset, and the per-frame pulses.

---
 rtl/ac97_frame_receiver.sv | 176 +++++++++++++++++
 tb/tb_ac97_frame_receiver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ac97_frame_receiver.sv
// AC97 receive path: resynchronises the codec serial link into clk, frames the
// 256-bit input frame and publishes the tag, register status and PCM capture slots.
module ac97_frame_receiver #(
   parameter int SYNC_STAGES   = 2,
   parameter int READY_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        audio_ready,
   input  logic        AUDIO_BIT_CLK,
   input  logic        AUDIO_SYNC,
   input  logic        AUDIO_SDATA_IN,
   output logic        codec_ready,
   output logic        codec_fault,
   output logic        frame_done,
   output logic        status_valid,
   output logic [6:0]  status_addr,
   output logic [15:0] status_data,
   output logic        pcm_valid,
   output logic [19:0] pcm_left,
   output logic [19:0] pcm_right,
   output logic        sync_err
);

   // state | meaning
   // IDLE  | codec held in reset or link disabled; counters parked at 0
   // HUNT  | waiting for the first SYNC rising edge
   // RECV  | framed; shifting bits and latching slot fields
   typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;

   localparam int CNT_W = $clog2(READY_TIMEOUT + 1);

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] bclk_ff, sync_ff, sdata_ff;
   logic        bclk_hist, sync_prev;
   logic        bclk_s, sync_s, sdata_s;
   logic        bit_edge, frame_start;
   logic [7:0]  bit_cnt;
   logic [19:0] shift_reg, shift_nxt;
   logic [4:0]  tag_hold;
   logic [6:0]  addr_hold;
   logic [15:0] data_hold;
   logic [19:0] left_hold, right_hold;
   logic        done_pend;
   logic [CNT_W-1:0] frame_cnt;

   assign bclk_s      = bclk_ff[SYNC_STAGES-1];
   assign sync_s      = sync_ff[SYNC_STAGES-1];
   assign sdata_s     = sdata_ff[SYNC_STAGES-1];
   assign bit_edge    = bclk_hist & ~bclk_s;
   assign frame_start = bit_edge & sync_s & ~sync_prev;
   assign shift_nxt   = {shift_reg[18:0], sdata_s};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bclk_ff   <= '0;
         sync_ff   <= '0;
         sdata_ff  <= '0;
         bclk_hist <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         bclk_ff   <= {bclk_ff[SYNC_STAGES-2:0], AUDIO_BIT_CLK};
         sync_ff   <= {sync_ff[SYNC_STAGES-2:0], AUDIO_SYNC};
         sdata_ff  <= {sdata_ff[SYNC_STAGES-2:0], AUDIO_SDATA_IN};
         bclk_hist <= bclk_s;
         if (bit_edge) sync_prev <= sync_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (audio_ready) state_nxt = HUNT;
         HUNT:    if (frame_start) state_nxt = RECV;
         RECV:    state_nxt = RECV;
         default: state_nxt = IDLE;
      endcase
      if (!audio_ready) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt      <= '0;
         shift_reg    <= '0;
         tag_hold     <= '0;
         addr_hold    <= '0;
         data_hold    <= '0;
         left_hold    <= '0;
         right_hold   <= '0;
         done_pend    <= 1'b0;
         frame_cnt    <= '0;
         codec_ready  <= 1'b0;
         codec_fault  <= 1'b0;
         frame_done   <= 1'b0;
         status_valid <= 1'b0;
         status_addr  <= '0;
         status_data  <= '0;
         pcm_valid    <= 1'b0;
         pcm_left     <= '0;
         pcm_right    <= '0;
         sync_err     <= 1'b0;
      end else begin
         frame_done   <= 1'b0;
         status_valid <= 1'b0;
         pcm_valid    <= 1'b0;
         sync_err     <= 1'b0;
         done_pend    <= 1'b0;
         if (!audio_ready) begin
            // A pending completion is dropped here: losing audio_ready wins.
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            codec_ready <= 1'b0;
            codec_fault <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  bit_cnt   <= '0;
                  frame_cnt <= '0;
               end
               HUNT: begin
                  if (frame_start) begin
                     shift_reg <= {19'b0, sdata_s};
                     bit_cnt   <= 8'd1;
                  end
               end
               RECV: begin
                  if (frame_start && bit_cnt != 8'd0) begin
                     sync_err  <= 1'b1;
                     shift_reg <= {19'b0, sdata_s};
                     bit_cnt   <= 8'd1;
                  end else if (bit_edge) begin
                     shift_reg <= shift_nxt;
                     bit_cnt   <= bit_cnt + 8'd1;
                     case (bit_cnt)
                        8'd15:   tag_hold   <= shift_nxt[15:11];
                        8'd35:   addr_hold  <= shift_nxt[18:12];
                        8'd55:   data_hold  <= shift_nxt[19:4];
                        8'd75:   left_hold  <= shift_nxt;
                        8'd95:   right_hold <= shift_nxt;
                        8'd255:  done_pend  <= 1'b1;
                        default: ;
                     endcase
                  end
               end
               default: ;
            endcase

            if (done_pend) begin
               frame_done  <= 1'b1;
               codec_ready <= tag_hold[4];
               if (tag_hold[3] && tag_hold[2]) begin
                  status_addr  <= addr_hold;
                  status_data  <= data_hold;
                  status_valid <= 1'b1;
               end
               if (tag_hold[1] && tag_hold[0]) begin
                  pcm_left  <= left_hold;
                  pcm_right <= right_hold;
                  pcm_valid <= 1'b1;
               end
               if (!tag_hold[4] && frame_cnt != CNT_W'(READY_TIMEOUT))
                  frame_cnt <= frame_cnt + 1'b1;
            end

            if (frame_cnt == CNT_W'(READY_TIMEOUT)) codec_fault <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ac97_frame_receiver.sv
// Directed bench for ac97_frame_receiver: a codec model drives frames, expected
// events go into a queue and a negedge monitor checks every DUT pulse against it.
module tb_ac97_frame_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        audio_ready = 1'b0;
   logic        AUDIO_BIT_CLK = 1'b0;
   logic        AUDIO_SYNC = 1'b0;
   logic        AUDIO_SDATA_IN = 1'b0;
   logic        codec_ready, codec_fault, frame_done, status_valid, pcm_valid, sync_err;
   logic [6:0]  status_addr;
   logic [15:0] status_data;
   logic [19:0] pcm_left, pcm_right;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit          is_sync;
      bit          ready;
      bit          fault;
      bit          sv;
      bit          pv;
      logic [6:0]  addr;
      logic [15:0] data;
      logic [19:0] left;
      logic [19:0] right;
   } exp_t;

   exp_t q[$];

   ac97_frame_receiver #(.SYNC_STAGES(2), .READY_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .audio_ready(audio_ready),
      .AUDIO_BIT_CLK(AUDIO_BIT_CLK), .AUDIO_SYNC(AUDIO_SYNC), .AUDIO_SDATA_IN(AUDIO_SDATA_IN),
      .codec_ready(codec_ready), .codec_fault(codec_fault), .frame_done(frame_done),
      .status_valid(status_valid), .status_addr(status_addr), .status_data(status_data),
      .pcm_valid(pcm_valid), .pcm_left(pcm_left), .pcm_right(pcm_right), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Codec drives data on the BIT_CLK rising edge; the receiver samples on the falling edge.
   task automatic send_bit(input logic s, input logic d);
      AUDIO_SYNC     = s;
      AUDIO_SDATA_IN = d;
      AUDIO_BIT_CLK  = 1'b1;
      #40;
      AUDIO_BIT_CLK  = 1'b0;
      #40;
   endtask

   task automatic send_idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                             input logic [19:0] s3, input logic [19:0] s4, input int nbits);
      logic [255:0] fr;
      fr = {tag, s1, s2, s3, s4, 160'b0};
      for (int i = 0; i < nbits; i++) send_bit(i < 16, fr[255-i]);
   endtask

   task automatic expect_frame(input bit rdy, input bit flt, input bit sv, input bit pv,
                               input logic [6:0] a, input logic [15:0] d,
                               input logic [19:0] l, input logic [19:0] r);
      exp_t e;
      e.is_sync = 1'b0; e.ready = rdy; e.fault = flt; e.sv = sv; e.pv = pv;
      e.addr = a; e.data = d; e.left = l; e.right = r;
      q.push_back(e);
   endtask

   task automatic expect_sync_err();
      exp_t e;
      e = '{is_sync: 1'b1, ready: 1'b0, fault: 1'b0, sv: 1'b0, pv: 1'b0,
            addr: '0, data: '0, left: '0, right: '0};
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (frame_done || sync_err) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_event: frame_done=%b sync_err=%b with nothing expected",
                        frame_done, sync_err);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.is_sync) begin
                  chk("sync_err_pulse", {frame_done, sync_err}, 32'b01);
               end else begin
                  chk("frame_done_pulse", {frame_done, sync_err}, 32'b10);
                  chk("codec_ready", codec_ready, e.ready);
                  chk("codec_fault", codec_fault, e.fault);
                  chk("status_valid", status_valid, e.sv);
                  chk("pcm_valid", pcm_valid, e.pv);
                  chk("status_addr", status_addr, e.addr);
                  chk("status_data", status_data, e.data);
                  chk("pcm_left", pcm_left, e.left);
                  chk("pcm_right", pcm_right, e.right);
               end
            end
         end else if (status_valid || pcm_valid) begin
            tests++;
            fails++;
            $display("FAIL stray_valid: status_valid=%b pcm_valid=%b without frame_done",
                     status_valid, pcm_valid);
         end
      end
   end

   task automatic chk_all_zero(input string name);
      chk(name, {codec_ready, codec_fault, frame_done, status_valid, pcm_valid, sync_err,
                 status_addr, status_data != 16'h0, pcm_left != 20'h0, pcm_right != 20'h0}, 32'h0);
   endtask

   initial begin
      // Reset with link disabled and BIT_CLK running.
      send_idle(10);
      chk_all_zero("reset_outputs");
      rst = 1'b1;
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 256);
      send_idle(4);
      chk_all_zero("idle_outputs");
      chk("idle_state", dut.state, 0);

      // Two back-to-back frames: fully valid, then tag-only.
      audio_ready = 1'b1;
      send_idle(4);
      expect_frame(1, 0, 1, 1, 7'h26, 16'h000F, 20'h12345, 20'hABCDE);
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 256);
      expect_frame(1, 0, 0, 0, 7'h26, 16'h000F, 20'h12345, 20'hABCDE);
      send_frame(16'h8000, 20'h7F000, 20'hBEEF0, 20'h00001, 20'hFFFFF, 256);

      // SYNC rises at bit 100 of a partial frame, then a clean frame follows.
      expect_sync_err();
      expect_frame(1, 0, 1, 1, 7'h7F, 16'hBEEF, 20'h00001, 20'hFFFFF);
      send_frame(16'hF800, 20'h55000, 20'h12340, 20'h11111, 20'h22222, 100);
      send_frame(16'hF800, 20'h7F000, 20'hBEEF0, 20'h00001, 20'hFFFFF, 256);
      #100;

      audio_ready = 1'b0;
      #100;
      chk("ready_clear_on_drop", codec_ready, 1'b0);
      chk("status_hold_on_drop", status_addr, 7'h7F);

      // Codec never ready: fault after the 4th frame, sticky until audio_ready drops.
      audio_ready = 1'b1;
      send_idle(4);
      for (int f = 0; f < 5; f++) begin
         expect_frame(0, f == 4, 0, 0, 7'h7F, 16'hBEEF, 20'h00001, 20'hFFFFF);
         send_frame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0, 256);
         #100;
         if (f == 2) chk("fault_low_after_3", codec_fault, 1'b0);
         if (f >= 3) chk("fault_high_after_4", codec_fault, 1'b1);
      end
      audio_ready = 1'b0;
      #100;
      chk("fault_clear_on_drop", codec_fault, 1'b0);

      // Asynchronous reset at bit 50 of a frame, then re-hunt and decode.
      audio_ready = 1'b1;
      send_idle(4);
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 50);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("async_reset_outputs");
      chk("async_reset_bitcnt", dut.bit_cnt, 0);
      #50;
      rst = 1'b1;
      send_idle(4);
      expect_frame(1, 0, 0, 1, 7'h00, 16'h0000, 20'h0ABCD, 20'h54321);
      send_frame(16'h9800, 20'h26000, 20'h000F0, 20'h0ABCD, 20'h54321, 256);
      #200;

      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
